// File: rtl/design1_pkg.sv
// Shared constants and helpers for the design1 dual-port block RAM.
package design1_pkg;

  localparam int unsigned DEPTH_DEFAULT = 2048;
  localparam int unsigned WORD_W        = 32;
  localparam int unsigned LANES         = 4;
  localparam int unsigned LANE_W        = WORD_W / LANES;
  localparam int unsigned IDX_W         = $clog2(DEPTH_DEFAULT);

  // Byte address to word index; addr[1:0] dropped, index wraps modulo depth.
  function automatic int unsigned word_index(input logic [31:0] byte_addr,
                                             input int unsigned depth);
    return (byte_addr >> 2) & (depth - 1);
  endfunction

endpackage

// File: rtl/design1_tdp_ram.sv
// True dual-port, read-first, byte-enabled RAM with per-port registered
// read data and synchronous active-high output reset.
module design1_tdp_ram
  import design1_pkg::*;
#(
  parameter int unsigned DEPTH     = DEPTH_DEFAULT,
  parameter bit          INIT_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst_a,
  input  logic              en_a,
  input  logic [LANES-1:0]  we_a,
  input  logic [31:0]       addr_a,
  input  logic [WORD_W-1:0] din_a,
  output logic [WORD_W-1:0] dout_a,
  input  logic              rst_b,
  input  logic              en_b,
  input  logic [LANES-1:0]  we_b,
  input  logic [31:0]       addr_b,
  input  logic [WORD_W-1:0] din_b,
  output logic [WORD_W-1:0] dout_b
);

  localparam int unsigned AW = $clog2(DEPTH);
  // Uninitialised contents are left as don't-care when zero init is off.
  localparam logic [LANE_W-1:0] INIT_BYTE = INIT_ZERO ? '0 : 'x;

  logic [AW-1:0]    idx_a, idx_b;
  logic [LANES-1:0] wr_a, wr_b;

  // Decode word indices and per-lane write strobes for both ports.
  always_comb begin
    idx_a = AW'(word_index(addr_a, DEPTH));
    idx_b = AW'(word_index(addr_b, DEPTH));
    wr_a  = en_a ? we_a : '0;
    wr_b  = en_b ? we_b : '0;
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      // One narrow array per byte lane keeps byte enables a plain write gate.
      logic [LANE_W-1:0] mem_lane [DEPTH] = '{default: INIT_BYTE};
      logic [LANE_W-1:0] dout_a_q = '0;
      logic [LANE_W-1:0] dout_b_q = '0;

      // Port B write is issued after port A so B wins a same-lane collision;
      // non-blocking reads return the pre-write word (read-first).
      always_ff @(posedge clk) begin
        if (wr_a[gi]) mem_lane[idx_a] <= din_a[gi*LANE_W +: LANE_W];
        if (wr_b[gi]) mem_lane[idx_b] <= din_b[gi*LANE_W +: LANE_W];
        if (rst_a)     dout_a_q <= '0;
        else if (en_a) dout_a_q <= mem_lane[idx_a];
        if (rst_b)     dout_b_q <= '0;
        else if (en_b) dout_b_q <= mem_lane[idx_b];
      end

      assign dout_a[gi*LANE_W +: LANE_W] = dout_a_q;
      assign dout_b[gi*LANE_W +: LANE_W] = dout_b_q;
    end
  endgenerate

endmodule

// File: rtl/design1_wrapper.sv
// Top-level wrapper mapping the BRAM_PORTA/B interface onto the RAM core.
module design1_wrapper
  import design1_pkg::*;
#(
  parameter int unsigned DEPTH     = DEPTH_DEFAULT,
  parameter bit          INIT_ZERO = 1'b1
) (
  input  logic        BRAM_PORTA_clk,
  input  logic        BRAM_PORTA_rst,
  input  logic [31:0] BRAM_PORTA_addr,
  input  logic [31:0] BRAM_PORTA_din,
  input  logic [3:0]  BRAM_PORTA_we,
  input  logic        BRAM_PORTA_en,
  output logic [31:0] BRAM_PORTA_dout,
  input  logic        BRAM_PORTB_clk,
  input  logic        BRAM_PORTB_rst,
  input  logic [31:0] BRAM_PORTB_addr,
  input  logic [31:0] BRAM_PORTB_din,
  input  logic [3:0]  BRAM_PORTB_we,
  input  logic        BRAM_PORTB_en,
  output logic [31:0] BRAM_PORTB_dout
);

  // Port B clock shares the port A net; it exists only for interface compatibility.
  logic unused_clk_b;
  assign unused_clk_b = BRAM_PORTB_clk;

  design1_tdp_ram #(
    .DEPTH     (DEPTH),
    .INIT_ZERO (INIT_ZERO)
  ) u_ram (
    .clk    (BRAM_PORTA_clk),
    .rst_a  (BRAM_PORTA_rst),
    .en_a   (BRAM_PORTA_en),
    .we_a   (BRAM_PORTA_we),
    .addr_a (BRAM_PORTA_addr),
    .din_a  (BRAM_PORTA_din),
    .dout_a (BRAM_PORTA_dout),
    .rst_b  (BRAM_PORTB_rst),
    .en_b   (BRAM_PORTB_en),
    .we_b   (BRAM_PORTB_we),
    .addr_b (BRAM_PORTB_addr),
    .din_b  (BRAM_PORTB_din),
    .dout_b (BRAM_PORTB_dout)
  );

endmodule

// File: tb/tb_design1_wrapper.sv
// Self-checking bench: directed scenarios plus random traffic against a
// word-level memory model.
module tb_design1_wrapper;

  localparam int unsigned DEPTH = 2048;

  logic        clk = 1'b0;
  logic        rst_a = 1'b0, rst_b = 1'b0;
  logic        en_a = 1'b0, en_b = 1'b0;
  logic [3:0]  we_a = '0, we_b = '0;
  logic [31:0] addr_a = '0, addr_b = '0, din_a = '0, din_b = '0;
  logic [31:0] dout_a, dout_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] ref_a = '0, ref_b = '0;

  always #5 clk = ~clk;

  design1_wrapper #(.DEPTH(DEPTH), .INIT_ZERO(1'b1)) dut (
    .BRAM_PORTA_clk  (clk),
    .BRAM_PORTA_rst  (rst_a),
    .BRAM_PORTA_addr (addr_a),
    .BRAM_PORTA_din  (din_a),
    .BRAM_PORTA_we   (we_a),
    .BRAM_PORTA_en   (en_a),
    .BRAM_PORTA_dout (dout_a),
    .BRAM_PORTB_clk  (clk),
    .BRAM_PORTB_rst  (rst_b),
    .BRAM_PORTB_addr (addr_b),
    .BRAM_PORTB_din  (din_b),
    .BRAM_PORTB_we   (we_b),
    .BRAM_PORTB_en   (en_b),
    .BRAM_PORTB_dout (dout_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (we[k]) r[8*k +: 8] = din[8*k +: 8];
    return r;
  endfunction

  // One clock of traffic: drive, advance the model, compare both outputs.
  task automatic step(input string tag,
                      input logic ra, input logic ea, input logic [3:0] wa,
                      input logic [31:0] aa, input logic [31:0] da,
                      input logic rb, input logic eb, input logic [3:0] wb,
                      input logic [31:0] ab, input logic [31:0] db);
    int unsigned ia, ib;
    rst_a = ra; en_a = ea; we_a = wa; addr_a = aa; din_a = da;
    rst_b = rb; en_b = eb; we_b = wb; addr_b = ab; din_b = db;
    @(posedge clk);
    ia = (aa >> 2) % DEPTH;
    ib = (ab >> 2) % DEPTH;
    if (ra) ref_a = '0; else if (ea) ref_a = ref_mem[ia];
    if (rb) ref_b = '0; else if (eb) ref_b = ref_mem[ib];
    if (ea) ref_mem[ia] = merge(ref_mem[ia], da, wa);
    if (eb) ref_mem[ib] = merge(ref_mem[ib], db, wb);
    #1;
    check({tag, "_a"}, dout_a, ref_a);
    check({tag, "_b"}, dout_b, ref_b);
    $display("%0t %s A(r%0b e%0b we%h @%08h d%08h -> %08h) B(r%0b e%0b we%h @%08h d%08h -> %08h)",
             $time, tag, ra, ea, wa, aa, da, dout_a, rb, eb, wb, ab, db, dout_b);
  endtask

  initial begin
    logic [31:0] held;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    #2;
    check("init_a", dout_a, 32'h0);
    check("init_b", dout_b, 32'h0);

    // Reset both ports with en=1 for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      step("rst", 1, 1, 4'h0, 32'h0, 32'h0, 1, 1, 4'h0, 32'h0, 32'h0);
      check("rst_zero_a", dout_a, 32'h0);
      check("rst_zero_b", dout_b, 32'h0);
    end

    // Port A fills words 0..7 with their byte address; port B reads them back.
    for (int i = 0; i < 8; i++)
      step("fill", 0, 1, 4'hf, 32'(4*i), 32'(4*i), 0, 0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      step("fill_rd", 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 4'h0, 32'(4*i), 32'h0);
      check("fill_rd_val", dout_b, 32'(4*i));
    end

    // Byte lanes.
    step("lane_w0", 0, 1, 4'hf, 32'h40, 32'hAABBCCDD, 0, 0, 4'h0, 32'h0, 32'h0);
    step("lane_w1", 0, 1, 4'b0101, 32'h40, 32'h11223344, 0, 0, 4'h0, 32'h0, 32'h0);
    step("lane_rd", 0, 1, 4'h0, 32'h40, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    check("lane_val", dout_a, 32'hAA22CC44);

    // Cross-port read-first collision.
    step("col_w5", 0, 1, 4'hf, 32'h8, 32'd5, 0, 0, 4'h0, 32'h0, 32'h0);
    step("col_w9", 0, 1, 4'hf, 32'h8, 32'd9, 0, 1, 4'h0, 32'h8, 32'h0);
    check("col_old", dout_b, 32'd5);
    step("col_rd", 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 4'h0, 32'h8, 32'h0);
    check("col_new", dout_b, 32'd9);

    // Same-port read-first.
    step("sp_wr", 0, 1, 4'hf, 32'h8, 32'd3, 0, 0, 4'h0, 32'h0, 32'h0);
    check("sp_old", dout_a, 32'd9);

    // Disabled port: no write, dout holds.
    held = dout_a;
    step("dis", 0, 0, 4'hf, 32'h10, 32'hDEADBEEF, 0, 0, 4'h0, 32'h0, 32'h0);
    check("dis_hold", dout_a, held);
    step("dis_rd", 0, 1, 4'h0, 32'h10, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    check("dis_nowr", dout_a, 32'h10);

    // Address wrap: 4*DEPTH aliases word 0.
    step("wrap_w", 0, 1, 4'hf, 32'(4*DEPTH), 32'd7, 0, 0, 4'h0, 32'h0, 32'h0);
    step("wrap_rd", 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 4'h0, 32'h0, 32'h0);
    check("wrap_val", dout_b, 32'd7);

    // Both ports write one word: B wins shared lanes.
    step("both_w", 0, 1, 4'b0011, 32'h60, 32'h11111111, 0, 1, 4'b0110, 32'h60, 32'h22222222);
    step("both_rd", 0, 1, 4'h0, 32'h60, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    check("both_val", dout_a, 32'h00222211);

    // Mid-burst reset of port B; contents survive; write under reset lands.
    step("burst", 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 4'h0, 32'h14, 32'h0);
    step("burst", 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 4'h0, 32'h18, 32'h0);
    step("burst_rst", 0, 0, 4'h0, 32'h0, 32'h0, 1, 1, 4'hf, 32'h70, 32'h12345678);
    check("burst_rst_zero", dout_b, 32'h0);
    step("keep_rd", 0, 1, 4'h0, 32'h4, 32'h0, 0, 1, 4'h0, 32'h70, 32'h0);
    check("keep_val", dout_a, 32'h4);
    check("rst_wr_val", dout_b, 32'h12345678);

    // Random traffic in a narrow window to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ra_addr, rb_addr;
      ra_addr = ($urandom & 32'hFFFF_E003) | (32'($urandom_range(0, 15)) << 2);
      rb_addr = ($urandom & 32'hFFFF_E003) | (32'($urandom_range(0, 15)) << 2);
      step("rand",
           ($urandom_range(0, 15) == 0), 1'($urandom), 4'($urandom), ra_addr, $urandom,
           ($urandom_range(0, 15) == 0), 1'($urandom), 4'($urandom), rb_addr, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
